// File: rtl/oh_pwrseq_pkg.sv
// Shared types and reset constants for the oh_pwrseq power-gating sequencer.
package oh_pwrseq_pkg;

  typedef enum logic [3:0] {
    ST_OFF,
    ST_RAMP_UP,
    ST_SETTLE,
    ST_RESTORE,
    ST_DEISO,
    ST_ON,
    ST_ISO,
    ST_SAVE,
    ST_RAMP_DN
  } state_t;

  // Per-bit reset values; nsleep is replicated to the stage count by the user.
  localparam logic RST_NSLEEP = 1'b0;
  localparam logic RST_ISO    = 1'b1;
  localparam logic RST_ACK    = 1'b1;

endpackage

// File: rtl/oh_pwrseq_if.sv
// Switch-control bundle between the power sequencer (master) and the
// switchable domain plus its requester (slave).
interface oh_pwrseq_if #(
  parameter int N  = 4,
  parameter int CW = 8
);

  logic          sleep_req;
  logic [CW-1:0] cfg_stagedly;
  logic [CW-1:0] cfg_settledly;
  logic          sleep_ack;
  logic          busy;
  logic [N-1:0]  nsleep;
  logic          iso;
  logic          ret_save;
  logic          ret_restore;

  modport master (
    input  sleep_req, cfg_stagedly, cfg_settledly,
    output sleep_ack, busy, nsleep, iso, ret_save, ret_restore
  );

  modport slave (
    output sleep_req, cfg_stagedly, cfg_settledly,
    input  sleep_ack, busy, nsleep, iso, ret_save, ret_restore
  );

endinterface

// File: rtl/oh_pwrseq_timer.sv
// Loadable CW-bit down-counter with a zero flag, shared by stage spacing and
// the post-ramp settle wait. It parks at zero rather than wrapping.
module oh_pwrseq_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/oh_pwrseq.sv
// Power-gating sequencer for one switchable domain: staggers switch-cell enables
// to limit inrush and brackets each transition with isolation and retention.
module oh_pwrseq
  import oh_pwrseq_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input logic         clk,
  input logic         reset,
  oh_pwrseq_if.master pwr
);

  state_t        state;
  logic [N-1:0]  nsleep_q;
  logic [N-1:0]  up_next;
  logic [N-1:0]  dn_next;
  logic          iso_q;
  logic          ack_q;
  logic          busy_q;
  logic          save_q;
  logic          restore_q;
  logic [CW-1:0] d_lat;
  logic [CW-1:0] s_lat;
  logic          tm_load;
  logic          tm_en;
  logic          tm_zero;
  logic [CW-1:0] tm_val;

  // Ramp-up turns on the next stage above the already-conducting ones.
  function automatic logic [N-1:0] stage_up(input logic [N-1:0] v);
    logic [N-1:0] r;
    r[0] = 1'b1;
    for (int i = 1; i < N; i++) r[i] = v[i-1];
    return r;
  endfunction

  function automatic logic [N-1:0] stage_dn(input logic [N-1:0] v);
    logic [N-1:0] r;
    r[N-1] = 1'b0;
    for (int i = 0; i < N - 1; i++) r[i] = v[i+1];
    return r;
  endfunction

  assign up_next = stage_up(nsleep_q);
  assign dn_next = stage_dn(nsleep_q);

  // The timer is reloaded on the same edge a stage moves, so each stage holds
  // for latched-value + 1 cycles; the stage that completes the ramp loads settle.
  always_comb begin
    tm_load = 1'b0;
    tm_en   = 1'b0;
    tm_val  = d_lat;
    case (state)
      ST_OFF: begin
        if (!pwr.sleep_req) begin
          tm_load = 1'b1;
          tm_val  = (&up_next) ? pwr.cfg_settledly : pwr.cfg_stagedly;
        end
      end
      ST_RAMP_UP: begin
        if (tm_zero) begin
          tm_load = 1'b1;
          tm_val  = (&up_next) ? s_lat : d_lat;
        end else begin
          tm_en = 1'b1;
        end
      end
      ST_SETTLE: tm_en = 1'b1;
      ST_SAVE:   tm_load = 1'b1;
      ST_RAMP_DN: begin
        if (tm_zero) tm_load = 1'b1;
        else         tm_en   = 1'b1;
      end
      default: ;
    endcase
  end

  oh_pwrseq_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tm_load),
    .en       (tm_en),
    .load_val (tm_val),
    .zero     (tm_zero)
  );

  // sleep_req is only looked at in the two stable states; every transition
  // runs to completion and sleep_ack holds its old value until the end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_OFF;
      nsleep_q  <= {N{RST_NSLEEP}};
      iso_q     <= RST_ISO;
      ack_q     <= RST_ACK;
      busy_q    <= 1'b0;
      save_q    <= 1'b0;
      restore_q <= 1'b0;
      d_lat     <= '0;
      s_lat     <= '0;
    end else begin
      save_q    <= 1'b0;
      restore_q <= 1'b0;
      case (state)
        ST_OFF: begin
          if (!pwr.sleep_req) begin
            state    <= (&up_next) ? ST_SETTLE : ST_RAMP_UP;
            nsleep_q <= up_next;
            busy_q   <= 1'b1;
            d_lat    <= pwr.cfg_stagedly;
            s_lat    <= pwr.cfg_settledly;
          end
        end
        ST_RAMP_UP: begin
          if (tm_zero) begin
            nsleep_q <= up_next;
            if (&up_next) state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tm_zero) begin
            state     <= ST_RESTORE;
            restore_q <= 1'b1;
          end
        end
        ST_RESTORE: begin
          state  <= ST_DEISO;
          iso_q  <= 1'b0;
          ack_q  <= 1'b0;
          busy_q <= 1'b0;
        end
        ST_DEISO: state <= ST_ON;
        ST_ON: begin
          if (pwr.sleep_req) begin
            state  <= ST_ISO;
            iso_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        ST_ISO: begin
          state  <= ST_SAVE;
          save_q <= 1'b1;
          d_lat  <= pwr.cfg_stagedly;
        end
        ST_SAVE: begin
          state    <= ST_RAMP_DN;
          nsleep_q <= dn_next;
        end
        ST_RAMP_DN: begin
          if (nsleep_q == '0) begin
            state  <= ST_OFF;
            ack_q  <= 1'b1;
            busy_q <= 1'b0;
          end else if (tm_zero) begin
            nsleep_q <= dn_next;
          end
        end
        default: begin
          state    <= ST_OFF;
          nsleep_q <= {N{RST_NSLEEP}};
          iso_q    <= RST_ISO;
          ack_q    <= RST_ACK;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pwr.nsleep      = nsleep_q;
  assign pwr.iso         = iso_q;
  assign pwr.sleep_ack   = ack_q;
  assign pwr.busy        = busy_q;
  assign pwr.ret_save    = save_q;
  assign pwr.ret_restore = restore_q;

endmodule
